adc_conversion_scheduler: RTL and testbench
===========================================

# adc_conversion_scheduler

Shares one `adc_control_nonbinary` SAR core between `NUM_CH` requesters, which are analog channels behind a one-hot input mux. Each request is served as one single-shot conversion:

- arbitrate round-robin;
- select the mux channel and wait for it to settle;
- apply that channel's averaging code;
- release the core from reset and let it run one conversion;
- capture the result, then return the core to reset.

It sits between the digital requesters and the SAR core and owns the core's `nrst` and `avg_control_in`.

## Interface
Parameters:
- `MATRIX_BITS`, 12: result width; must match the core.
- `NUM_CH`, 4: number of requesters/mux channels, 2..16.
- `SETTLE_CYCLES`, 4: mux settle time in cycles, ≥1.
- `TIMEOUT_CYCLES`, 160: conversion watchdog; must be > 12+4·31.

Ports:
- `clk` in 1: the single clock.
- `nrst` in 1: asynchronous, active-low reset.
- `req_in` in `NUM_CH`: per-channel request level, held until that channel's ack.
- `avg_ctrl_in` in 3·`NUM_CH`: averaging code of channel i at bits [3i+2:3i].
- `ack_out` out `NUM_CH`: one-cycle pulse to the served channel.
- `result_out` out `MATRIX_BITS`: conversion result, valid while any `ack_out` bit is high.
- `result_ch_out` out $clog2(`NUM_CH`): index of the served channel.
- `err_out` out 1: watchdog abort flag, valid with the ack.
- `busy_out` out 1: high in every state except IDLE.
- `mux_sel_out` out `NUM_CH`: one-hot analog mux select, all-zero when idle.
- `adc_nrst_out` out 1: reset to the core, registered, low when idle.
- `adc_avg_control_out` out 3: averaging code driven to the core.
- `adc_conv_finished_in` in 1: core `conv_finished_out`.
- `adc_result_in` in `MATRIX_BITS`: core `result_out`.

## Operation
State machine: IDLE → SETTLE → START → CONVERT → DONE → IDLE.

- **IDLE**
  - Drives `adc_nrst_out`=0 and `mux_sel_out`=0.
  - If any `req_in` bit is high, grant the first requesting channel after the last-served pointer, wrapping around.
  - Latch the channel index and its 3-bit averaging code; `mux_sel_out` becomes one-hot for that channel.
  - Load the settle counter with `SETTLE_CYCLES`; go to SETTLE.
- **SETTLE**
  - Decrement the counter. After `SETTLE_CYCLES` cycles, set `adc_nrst_out`=1 and go to START.
- **START**
  - Lasts exactly 1 cycle: the core's sampling cycle. `adc_conv_finished_in` is high here and is ignored.
  - Clear the watchdog; go to CONVERT.
- **CONVERT**
  - Increment the watchdog each cycle.
  - On `adc_conv_finished_in`=1: capture `adc_result_in` into `result_out`, clear `err`, go to DONE.
  - If the watchdog reaches `TIMEOUT_CYCLES` first: `result_out`=0, `err`=1, go to DONE.
  - On either exit, `adc_nrst_out`=0 and `mux_sel_out`=0 at that same edge.
- **DONE**
  - Lasts 1 cycle. `ack_out`[ch]=1 and `result_ch_out`=ch.
  - Update the last-served pointer to ch; go to IDLE.

Other rules:
- `adc_avg_control_out` holds the latched code from the grant until the next grant. Codes >4 pass through unchanged; the core treats them as 1 sample.
- A `req_in` bit that drops mid-service does not abort: the conversion completes and the ack is still pulsed.
- A requester must drop `req_in` by the edge that ends its ack cycle. A request still high in the following IDLE cycle is a new request.
- `avg_ctrl_in` is sampled only at grant.
- An `nrst` assertion mid-operation aborts immediately with no ack.
- All outputs are registered.

## Timing
Reset values:
- `ack_out`=0, `result_out`=0, `result_ch_out`=0, `err_out`=0, `busy_out`=0.
- `mux_sel_out`=0, `adc_nrst_out`=0, `adc_avg_control_out`=0.
- State IDLE; pointer = `NUM_CH`-1, so channel 0 wins first.

Core conversion time:
- Tc = 12+4L cycles from the `adc_nrst_out` rise to `adc_conv_finished_in` high again.
- L = 1, 3, 7, 15, 31 for codes 0/≥5, 1, 2, 3, 4.

Latency:
- Grant edge E0, taken in an IDLE cycle with a request present.
- `adc_nrst_out` rises at E0+S, where S=`SETTLE_CYCLES`.
- The ack cycle begins at E0+S+Tc+1. At defaults with code 0 this is E0+21.
- Minimum request-to-request spacing, back-to-back: S+Tc+3 cycles.

`adc_nrst_out` is a flop output, so it is glitch-free toward the core's asynchronous reset.

## Structure
- Shared package `adc_pkg` holds:
  - the state enum;
  - averaging-code constants AVG_1/3/7/15/31 (0..4);
  - function `adc_conv_cycles(code)` returning 12+4L;
  - the default TIMEOUT constant.
- Sub-module `adc_rr_arbiter`: combinational one-hot round-robin pick from (`req`, pointer), parameterized by `NUM_CH`.

## Test plan
- Reset, then `req_in`=0001, ch0 code 0, core model present: `mux_sel_out`=0001; `adc_nrst_out` high 4 cycles after grant; ack[0] at E0+21 with `result_out` = model value (e.g. 12'd1234); `err_out`=0.
- `req_in`=1111 held, each channel dropping its request after its ack: service order 0,1,2,3. Re-raise all: order 0,1,2,3 again. No cycle ever has two mux bits set.
- ch2 only, code 4: ack at E0+4+136+1; `adc_avg_control_out`=4 throughout; a change of `avg_ctrl_in` mid-conversion is ignored.
- `adc_conv_finished_in` tied low after START: at `TIMEOUT_CYCLES`, ack pulses with `err_out`=1 and `result_out`=0; `adc_nrst_out`=0 on the same edge.
- `nrst` pulsed low mid-CONVERT: all outputs return to reset values asynchronously; no ack; the next request is served starting from channel 0.
- ch1 drops `req_in` during SETTLE: conversion completes and ack[1] still pulses. ch1 re-raising `req_in` in the ack cycle is served as a new request.

Source files
------------

// File: rtl/adc_conversion_scheduler_pkg.sv
// Shared types and constants for the SAR conversion scheduler and its SAR core.
// Holds the FSM encoding, averaging-code names and the nominal core conversion time.
package adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_START,
        ST_CONVERT,
        ST_DONE
    } state_t;

    localparam logic [2:0] AVG_1  = 3'd0;
    localparam logic [2:0] AVG_3  = 3'd1;
    localparam logic [2:0] AVG_7  = 3'd2;
    localparam logic [2:0] AVG_15 = 3'd3;
    localparam logic [2:0] AVG_31 = 3'd4;

    localparam int DEFAULT_TIMEOUT = 160;

    // Cycles from core reset release to conv_finished; codes above 4 act as one sample.
    function automatic int adc_conv_cycles(input logic [2:0] code);
        int l;
        case (code)
            AVG_3:   l = 3;
            AVG_7:   l = 7;
            AVG_15:  l = 15;
            AVG_31:  l = 31;
            default: l = 1;
        endcase
        return 12 + 4 * l;
    endfunction

endpackage

// File: rtl/adc_conversion_scheduler_if.sv
// Requester-side and SAR-core-side signals of the conversion scheduler.
// slave is the scheduler's view; master is the requesters plus core.
interface adc_conversion_scheduler_if #(
    parameter int MATRIX_BITS = 12,
    parameter int NUM_CH      = 4
);
    localparam int CW = $clog2(NUM_CH);

    logic [NUM_CH-1:0]      req_in;
    logic [3*NUM_CH-1:0]    avg_ctrl_in;
    logic [NUM_CH-1:0]      ack_out;
    logic [MATRIX_BITS-1:0] result_out;
    logic [CW-1:0]          result_ch_out;
    logic                   err_out;
    logic                   busy_out;
    logic [NUM_CH-1:0]      mux_sel_out;
    logic                   adc_nrst_out;
    logic [2:0]             adc_avg_control_out;
    logic                   adc_conv_finished_in;
    logic [MATRIX_BITS-1:0] adc_result_in;

    modport slave (
        input  req_in, avg_ctrl_in, adc_conv_finished_in, adc_result_in,
        output ack_out, result_out, result_ch_out, err_out, busy_out,
               mux_sel_out, adc_nrst_out, adc_avg_control_out
    );

    modport master (
        output req_in, avg_ctrl_in, adc_conv_finished_in, adc_result_in,
        input  ack_out, result_out, result_ch_out, err_out, busy_out,
               mux_sel_out, adc_nrst_out, adc_avg_control_out
    );

endinterface

// File: rtl/adc_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr, wrapping.
// Zero latency; no backpressure, any is simply the OR of all requests.
module adc_rr_arbiter #(
    parameter int NUM_CH = 4,
    localparam int CW    = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CW-1:0]     ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CW-1:0]     grant_idx,
    output logic              any
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = (int'(ptr) + i) % NUM_CH;
            if (grant == '0 && req[CW'(idx)]) begin
                grant[CW'(idx)] = 1'b1;
                grant_idx       = CW'(idx);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/adc_conversion_scheduler.sv
// Time-shares one SAR core across NUM_CH muxed channels, one single-shot conversion per request.
// Ack at grant+SETTLE+Tc+1; requesters hold req until ack, the core is never stalled.
module adc_conversion_scheduler
    import adc_pkg::*;
#(
    parameter int MATRIX_BITS    = 12,
    parameter int NUM_CH         = 4,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input logic                       clk,
    input logic                       nrst,
    adc_conversion_scheduler_if.slave bus
);

    localparam int CW = $clog2(NUM_CH);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYCLES);
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);

    state_t                 state;
    logic [CW-1:0]          ptr;
    logic [CW-1:0]          ch;
    logic [SW-1:0]          settle_cnt;
    logic [WW-1:0]          wdog;
    logic [NUM_CH-1:0]      ack;
    logic [MATRIX_BITS-1:0] result;
    logic [CW-1:0]          result_ch;
    logic                   err;
    logic                   busy;
    logic [NUM_CH-1:0]      mux_sel;
    logic                   adc_nrst;
    logic [2:0]             avg_code;

    logic [NUM_CH-1:0]      grant;
    logic [CW-1:0]          grant_idx;
    logic                   any_req;

    adc_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req       (bus.req_in),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any_req)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= ST_IDLE;
            ptr        <= CW'(NUM_CH - 1);
            ch         <= '0;
            settle_cnt <= '0;
            wdog       <= '0;
            ack        <= '0;
            result     <= '0;
            result_ch  <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            mux_sel    <= '0;
            adc_nrst   <= 1'b0;
            avg_code   <= '0;
        end else begin
            ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        ch         <= grant_idx;
                        avg_code   <= bus.avg_ctrl_in[3*int'(grant_idx) +: 3];
                        mux_sel    <= grant;
                        settle_cnt <= SETTLE_LD;
                        busy       <= 1'b1;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SW'(1)) begin
                        adc_nrst <= 1'b1;
                        state    <= ST_START;
                    end else begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end
                end
                // Core sampling cycle: its conv_finished is still high from reset here.
                ST_START: begin
                    wdog  <= '0;
                    state <= ST_CONVERT;
                end
                ST_CONVERT: begin
                    if (bus.adc_conv_finished_in || wdog == WDOG_LAST) begin
                        result    <= bus.adc_conv_finished_in ? bus.adc_result_in : '0;
                        err       <= !bus.adc_conv_finished_in;
                        adc_nrst  <= 1'b0;
                        mux_sel   <= '0;
                        ack       <= NUM_CH'(1) << ch;
                        result_ch <= ch;
                        state     <= ST_DONE;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
                end
                ST_DONE: begin
                    ptr   <= ch;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ack_out             = ack;
    assign bus.result_out          = result;
    assign bus.result_ch_out       = result_ch;
    assign bus.err_out             = err;
    assign bus.busy_out            = busy;
    assign bus.mux_sel_out         = mux_sel;
    assign bus.adc_nrst_out        = adc_nrst;
    assign bus.adc_avg_control_out = avg_code;

endmodule

// File: tb/tb_adc_conversion_scheduler.sv
// Bench for adc_conversion_scheduler: behavioural SAR core plus timing/order reference model.
module tb_adc_conversion_scheduler;

    localparam int MB = 12;
    localparam int N  = 4;
    localparam int S  = 4;
    localparam int T  = 160;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int model_ptr = N - 1;

    adc_conversion_scheduler_if #(.MATRIX_BITS(MB), .NUM_CH(N)) bus();

    adc_conversion_scheduler #(
        .MATRIX_BITS(MB), .NUM_CH(N), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus.slave)
    );

    function automatic int tc_of(input int code);
        int l;
        case (code)
            1: l = 3;
            2: l = 7;
            3: l = 15;
            4: l = 31;
            default: l = 1;
        endcase
        return 12 + 4 * l;
    endfunction

    // Behavioural SAR core: finished high in reset and in its sampling cycle, then after Tc.
    int          k = 0;
    int          tc = 16;
    logic        stuck = 1'b0;
    logic [MB-1:0] core_val = '0;
    logic        fin;
    always @(negedge clk) begin
        if (bus.adc_nrst_out !== 1'b1) begin
            k   = 0;
            fin = 1'b1;
        end else begin
            k++;
            if (k == 1) tc = tc_of(int'(bus.adc_avg_control_out));
            fin = (k == 1) || (!stuck && k >= tc + 1);
        end
        bus.adc_conv_finished_in = fin;
        bus.adc_result_in = (fin && k > 1) ? core_val : MB'($urandom);
    end

    int onehot_viol = 0;
    always @(negedge clk) if (!$onehot0(bus.mux_sel_out)) onehot_viol++;

    task automatic wait_ack(input int budget, output int at, output logic prev_nrst, output logic ok);
        logic pn;
        pn = bus.adc_nrst_out;
        prev_nrst = pn;
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.ack_out !== '0) begin
                at = cyc; prev_nrst = pn; ok = 1'b1;
                break;
            end
            pn = bus.adc_nrst_out;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL ack_wait no ack within %0d cycles (cyc=%0d)", budget, cyc);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        bus.req_in = '0;
        bus.avg_ctrl_in = '0;
        repeat (3) @(negedge clk);
        total++; if (bus.ack_out !== 4'd0) begin bad++; $display("FAIL rst_ack got=%0h exp=0", bus.ack_out); end
        total++; if (bus.result_out !== 12'd0) begin bad++; $display("FAIL rst_result got=%0h exp=0", bus.result_out); end
        total++; if (bus.result_ch_out !== 2'd0) begin bad++; $display("FAIL rst_result_ch got=%0h exp=0", bus.result_ch_out); end
        total++; if (bus.err_out !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", bus.err_out); end
        total++; if (bus.busy_out !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy_out); end
        total++; if (bus.mux_sel_out !== 4'd0) begin bad++; $display("FAIL rst_mux got=%0h exp=0", bus.mux_sel_out); end
        total++; if (bus.adc_nrst_out !== 1'b0) begin bad++; $display("FAIL rst_adc_nrst got=%b exp=0", bus.adc_nrst_out); end
        total++; if (bus.adc_avg_control_out !== 3'd0) begin bad++; $display("FAIL rst_avg got=%0d exp=0", bus.adc_avg_control_out); end
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (bus.busy_out !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", bus.busy_out); end
        model_ptr = N - 1;
    endtask

    task automatic test_single();
        logic [11:0] a;
        int e0, at;
        logic pn, ok, seen;
        a = 12'($urandom);
        a[2:0] = 3'd0;
        bus.avg_ctrl_in = a;
        core_val = MB'($urandom_range(1, 4095));
        bus.req_in = 4'b0001;
        e0 = cyc + 1;
        @(negedge clk);
        total++; if (bus.mux_sel_out !== 4'b0001) begin bad++; $display("FAIL single_mux got=%0h exp=1", bus.mux_sel_out); end
        total++; if (bus.busy_out !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", bus.busy_out); end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.adc_nrst_out === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        total++; if (!seen || cyc != e0 + S) begin bad++; $display("FAIL single_nrst_rise got=%0d exp=%0d", cyc - e0, S); end
        wait_ack(100, at, pn, ok);
        if (ok) begin
            total++; if (at != e0 + S + tc_of(0) + 1) begin bad++; $display("FAIL single_ack_time got=%0d exp=%0d", at - e0, S + tc_of(0) + 1); end
            total++; if (bus.ack_out !== 4'b0001) begin bad++; $display("FAIL single_ack got=%0h exp=1", bus.ack_out); end
            total++; if (bus.result_out !== core_val) begin bad++; $display("FAIL single_result got=%0d exp=%0d", bus.result_out, core_val); end
            total++; if (bus.err_out !== 1'b0) begin bad++; $display("FAIL single_err got=%b exp=0", bus.err_out); end
            total++; if (bus.result_ch_out !== 2'd0) begin bad++; $display("FAIL single_ch got=%0d exp=0", bus.result_ch_out); end
        end
        bus.req_in = '0;
        model_ptr = 0;
        @(negedge clk);
        total++; if (bus.ack_out !== 4'd0) begin bad++; $display("FAIL single_ack_pulse got=%0h exp=0", bus.ack_out); end
    endtask

    task automatic test_round_robin();
        logic [11:0] a;
        int codes[N];
        logic [3:0] pend, exp_ack;
        int e0, at, exp_ch;
        logic pn, ok;
        a = 12'($urandom);
        for (int c = 0; c < N; c++) codes[c] = int'(a[3*c +: 3]);
        bus.avg_ctrl_in = a;
        for (int round = 0; round < 2; round++) begin
            core_val = MB'($urandom);
            pend = '1;
            bus.req_in = pend;
            e0 = cyc + 1;
            for (int n = 0; n < N; n++) begin
                exp_ch = -1;
                for (int i = 1; i <= N; i++) begin
                    int c;
                    c = (model_ptr + i) % N;
                    if (exp_ch < 0 && pend[c]) exp_ch = c;
                end
                exp_ack = 4'(1) << exp_ch;
                wait_ack(300, at, pn, ok);
                if (!ok) return;
                total++; if (bus.ack_out !== exp_ack) begin bad++; $display("FAIL rr_order got=%0h exp=%0h", bus.ack_out, exp_ack); end
                total++; if (at != e0 + S + tc_of(codes[exp_ch]) + 1) begin bad++; $display("FAIL rr_time ch%0d got=%0d exp=%0d", exp_ch, at - e0, S + tc_of(codes[exp_ch]) + 1); end
                total++; if (bus.result_out !== core_val) begin bad++; $display("FAIL rr_result got=%0d exp=%0d", bus.result_out, core_val); end
                total++; if (bus.adc_avg_control_out !== 3'(codes[exp_ch])) begin bad++; $display("FAIL rr_avg got=%0d exp=%0d", bus.adc_avg_control_out, codes[exp_ch]); end
                pend[exp_ch] = 1'b0;
                bus.req_in = pend;
                model_ptr = exp_ch;
                core_val = MB'($urandom);
                e0 = at + 2;
            end
            repeat (2) @(negedge clk);
        end
        total++; if (onehot_viol != 0) begin bad++; $display("FAIL rr_mux_onehot got=%0d exp=0", onehot_viol); end
    endtask

    task automatic test_long_code();
        logic [11:0] a;
        int e0, at, avg_bad;
        logic ok;
        a = 12'($urandom);
        a[8:6] = 3'd4;
        bus.avg_ctrl_in = a;
        core_val = MB'($urandom);
        bus.req_in = 4'b0100;
        e0 = cyc + 1;
        avg_bad = 0; ok = 1'b0; at = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cyc == e0 + S + 10) begin
                a = 12'($urandom);
                a[8:6] = 3'd1;
                bus.avg_ctrl_in = a;
            end
            if (bus.ack_out !== '0) begin at = cyc; ok = 1'b1; break; end
            if (bus.adc_avg_control_out !== 3'd4) avg_bad++;
        end
        total++; if (!ok || at != e0 + S + 137) begin bad++; $display("FAIL long_time got=%0d exp=%0d", at - e0, S + 137); end
        total++; if (bus.ack_out !== 4'b0100) begin bad++; $display("FAIL long_ack got=%0h exp=4", bus.ack_out); end
        total++; if (bus.result_out !== core_val) begin bad++; $display("FAIL long_result got=%0d exp=%0d", bus.result_out, core_val); end
        total++; if (avg_bad != 0 || bus.adc_avg_control_out !== 3'd4) begin bad++; $display("FAIL long_avg_hold got=%0d exp=4 bad_cycles=%0d", bus.adc_avg_control_out, avg_bad); end
        bus.req_in = '0;
        model_ptr = 2;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        logic [11:0] a;
        int e0, at;
        logic pn, ok;
        stuck = 1'b1;
        a = 12'($urandom);
        bus.avg_ctrl_in = a;
        core_val = MB'($urandom_range(1, 4095));
        bus.req_in = 4'b1000;
        e0 = cyc + 1;
        wait_ack(400, at, pn, ok);
        if (ok) begin
            total++; if (at != e0 + S + T + 1) begin bad++; $display("FAIL to_time got=%0d exp=%0d", at - e0, S + T + 1); end
            total++; if (bus.ack_out !== 4'b1000) begin bad++; $display("FAIL to_ack got=%0h exp=8", bus.ack_out); end
            total++; if (bus.err_out !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", bus.err_out); end
            total++; if (bus.result_out !== 12'd0) begin bad++; $display("FAIL to_result got=%0d exp=0", bus.result_out); end
            total++; if (pn !== 1'b1 || bus.adc_nrst_out !== 1'b0) begin bad++; $display("FAIL to_nrst_edge got=%b%b exp=10", pn, bus.adc_nrst_out); end
            total++; if (bus.mux_sel_out !== 4'd0) begin bad++; $display("FAIL to_mux got=%0h exp=0", bus.mux_sel_out); end
        end
        bus.req_in = '0;
        model_ptr = 3;
        @(negedge clk);
        stuck = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic [11:0] a;
        int e0, at;
        logic pn, ok;
        a = 12'($urandom);
        a[2:0] = 3'd4;
        bus.avg_ctrl_in = a;
        bus.req_in = 4'b1001;
        e0 = cyc + 1;
        @(negedge clk);
        total++; if (bus.mux_sel_out !== 4'b0001) begin bad++; $display("FAIL ar_grant got=%0h exp=1", bus.mux_sel_out); end
        while (cyc < e0 + S + 10) @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        total++; if (bus.busy_out !== 1'b0) begin bad++; $display("FAIL ar_busy got=%b exp=0", bus.busy_out); end
        total++; if (bus.mux_sel_out !== 4'd0) begin bad++; $display("FAIL ar_mux got=%0h exp=0", bus.mux_sel_out); end
        total++; if (bus.adc_nrst_out !== 1'b0) begin bad++; $display("FAIL ar_adc_nrst got=%b exp=0", bus.adc_nrst_out); end
        total++; if (bus.adc_avg_control_out !== 3'd0) begin bad++; $display("FAIL ar_avg got=%0d exp=0", bus.adc_avg_control_out); end
        total++; if (bus.ack_out !== 4'd0) begin bad++; $display("FAIL ar_ack got=%0h exp=0", bus.ack_out); end
        a[2:0] = 3'd0;
        bus.avg_ctrl_in = a;
        core_val = MB'($urandom);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        model_ptr = N - 1;
        e0 = cyc + 1;
        wait_ack(100, at, pn, ok);
        if (ok) begin
            total++; if (bus.ack_out !== 4'b0001) begin bad++; $display("FAIL ar_restart_ch got=%0h exp=1", bus.ack_out); end
            total++; if (at != e0 + S + tc_of(0) + 1) begin bad++; $display("FAIL ar_restart_time got=%0d exp=%0d", at - e0, S + tc_of(0) + 1); end
        end
        bus.req_in = '0;
        model_ptr = 0;
        @(negedge clk);
    endtask

    task automatic test_drop_req();
        logic [11:0] a;
        int e0, at, a0, code;
        logic pn, ok;
        a = 12'($urandom);
        code = int'(a[5:3]);
        bus.avg_ctrl_in = a;
        core_val = MB'($urandom);
        bus.req_in = 4'b0010;
        e0 = cyc + 1;
        repeat (2) @(negedge clk);
        bus.req_in = '0;
        wait_ack(200, at, pn, ok);
        if (!ok) return;
        total++; if (bus.ack_out !== 4'b0010) begin bad++; $display("FAIL drop_ack got=%0h exp=2", bus.ack_out); end
        total++; if (at != e0 + S + tc_of(code) + 1) begin bad++; $display("FAIL drop_time got=%0d exp=%0d", at - e0, S + tc_of(code) + 1); end
        total++; if (bus.result_out !== core_val) begin bad++; $display("FAIL drop_result got=%0d exp=%0d", bus.result_out, core_val); end
        a0 = at;
        bus.req_in = 4'b0010;
        core_val = MB'($urandom);
        @(negedge clk);
        total++; if (bus.mux_sel_out !== 4'd0) begin bad++; $display("FAIL rereq_idle_mux got=%0h exp=0", bus.mux_sel_out); end
        @(negedge clk);
        total++; if (bus.mux_sel_out !== 4'b0010) begin bad++; $display("FAIL rereq_grant got=%0h exp=2", bus.mux_sel_out); end
        wait_ack(200, at, pn, ok);
        if (ok) begin
            total++; if (at != a0 + 2 + S + tc_of(code) + 1) begin bad++; $display("FAIL rereq_time got=%0d exp=%0d", at - a0, 2 + S + tc_of(code) + 1); end
            total++; if (bus.ack_out !== 4'b0010 || bus.result_out !== core_val) begin bad++; $display("FAIL rereq_ack got=%0h/%0d exp=2/%0d", bus.ack_out, bus.result_out, core_val); end
        end
        bus.req_in = '0;
        model_ptr = 1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_long_code();
        test_timeout();
        test_async_reset();
        test_drop_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
